universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised WIDTH-bit register with complemented output, parallel load and multi-cycle shift/rotate operations under a start/busy/done handshake. It extends the team's single-bit storage element (Q/Qbar with active-low clear) to a bus-wide, edge-triggered register bank. It is used as a data-path register wherever serial shifting or rotation of a stored word is needed.

## Interface
- WIDTH, 8: register width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1): width of the shift-amount field.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset (0 = clear).
- load  in  1  parallel-load request; sampled only in IDLE.
- d_par  in  WIDTH  parallel load data.
- start  in  1  shift-operation request; sampled only in IDLE.
- op  in  2  operation, captured on start: SHL=0, SHR=1, ROL=2, ROR=3.
- amount  in  CNT_W  number of single-bit steps, captured on start.
- sin  in  1  serial fill bit for SHL/SHR; sampled on every shift edge.
- q  out  WIDTH  register contents.
- qbar  out  WIDTH  ~q, combinational from q.
- sout  out  1  registered copy of the last bit shifted or rotated out.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- In IDLE, if load=1: q <= d_par and state stays IDLE. load has priority over a simultaneous start; that start is dropped.
- In IDLE, if start=1 and load=0: capture op and cnt <= min(amount, WIDTH).
  - cnt=0 goes to DONE.
  - Otherwise go to SHIFT.
- On each edge in SHIFT, perform one step and decrement cnt. When the step made has cnt=1, go to DONE.
- DONE: done=1 for that cycle, then go to IDLE.
- While busy, load and start are ignored and are not queued. op and amount changes have no effect.
- Step definitions:
  - SHL: q <= {q[W-2:0], sin}; sout <= q[W-1].
  - SHR: q <= {sin, q[W-1:1]}; sout <= q[0].
  - ROL: q <= {q[W-2:0], q[W-1]}; sout <= q[W-1]. sin is ignored.
  - ROR: q <= {q[0], q[W-1:1]}; sout <= q[0]. sin is ignored.
- Reset values: q=0, qbar=all ones, sout=0, busy=0, done=0, state=IDLE, cnt=0.
- Reset asserted mid-operation:
  - The operation aborts immediately and asynchronously.
  - No done pulse is produced, and the remaining steps are discarded.

## Timing
- start sampled at edge E0 with N≥1 after clamping:
  - Steps happen at edges E1..EN.
  - done=1 during the cycle between E(N) and E(N+1).
  - busy is high from E0 to E(N+1).
  - The next start can be sampled at E(N+2) at the earliest.
- N=0: DONE is entered at E0, done is high for one cycle, and IDLE returns at E1. q is unchanged.
- load: q is updated at the sampling edge. busy stays 0.
- qbar tracks q with zero cycles of latency.

## Structure
- Package usr_pkg holds:
  - typedef enum logic [1:0] op_e {SHL, SHR, ROL, ROR}.
  - typedef enum state_e {IDLE, SHIFT, DONE}.
- Sub-module usr_step: a purely combinational one-step shifter.
  - Inputs: q, op, sin.
  - Outputs: next q and the out-bit.
  - The top level holds the FSM, the counter and the registers.

## Test plan
- Reset: hold reset=0 with load=1 and d_par=8'hA5 -> q=8'h00, qbar=8'hFF, busy=0, done=0, sout=0. Release reset and load -> q=8'hA5, qbar=8'h5A one edge later, busy stays 0.
- ROL: q=8'h81, op=ROL, amount=3 -> q=8'h0C after E3, sout=0. done is high only in cycle E3..E4; busy is high E0..E4.
- SHR: q=8'hF0, sin=1, amount=4 -> q=8'hFF, sout=0. Each intermediate value is checked: F8, FC, FE.
- SHL clamp: q=8'hA5, sin=0, amount=15 -> exactly 8 steps, q=8'h00, sout=1, done after E8.
- Conflicts:
  - start and load asserted together in IDLE -> load wins, q=d_par, busy stays 0.
  - load or start pulsed while busy -> ignored.
  - amount=0 -> single done pulse, q unchanged.
- Reset mid-operation: reset asserted after 2 of 5 SHL steps -> q=8'h00, busy=0 immediately. No done pulse follows, and the next start behaves normally.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
package usr_pkg;

  typedef enum logic [1:0] {
    SHL = 2'd0,
    SHR = 2'd1,
    ROL = 2'd2,
    ROR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/usr_if.sv
// Control/data bundle of the universal shift register.
// master drives requests and data; slave returns contents and status.
interface usr_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  import usr_pkg::*;

  logic             load;
  logic [WIDTH-1:0] d_par;
  logic             start;
  op_e              op;
  logic [CNT_W-1:0] amount;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output load, d_par, start, op, amount, sin,
    input  q, qbar, sout, busy, done
  );

  modport slave (
    input  load, d_par, start, op, amount, sin,
    output q, qbar, sout, busy, done
  );

endinterface

// File: rtl/usr_step.sv
// One-step shifter/rotator, purely combinational (zero latency).
// There is no handshake: the next value and the out-bit follow the inputs directly.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             out_bit
);

  always_comb begin
    q_nxt   = q;
    out_bit = 1'b0;
    case (op)
      SHL: begin
        q_nxt   = {q[WIDTH-2:0], sin};
        out_bit = q[WIDTH-1];
      end
      SHR: begin
        q_nxt   = {sin, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      ROL: begin
        q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      ROR: begin
        q_nxt   = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_nxt   = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register: a parallel load takes 1 edge; a shift of N steps is busy for N+1 edges, then done pulses for 1 cycle.
// While busy, new load and start requests are dropped without being queued.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic  clk,
  input logic  reset,
  usr_if.slave bus
);

  localparam logic [CNT_W-1:0] WMAX = CNT_W'(WIDTH);

  state_e           state;
  op_e              op_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_r;
  logic             sout_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q_nxt;
  logic             out_bit;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_r),
    .op      (op_r),
    .sin     (bus.sin),
    .q_nxt   (q_nxt),
    .out_bit (out_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_r   <= SHL;
      cnt    <= '0;
      q_r    <= '0;
      sout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.load) begin
            q_r <= bus.d_par;
          end else if (bus.start) begin
            op_r   <= bus.op;
            busy_r <= 1'b1;
            // Amounts beyond the width are clamped to a full-width pass.
            cnt    <= (bus.amount > WMAX) ? WMAX : bus.amount;
            if (bus.amount == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          q_r    <= q_nxt;
          sout_r <= out_bit;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.qbar = ~q_r;
  assign bus.sout = sout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed and randomized checks of universal_shift_reg against an arithmetic reference model.
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cur_q;
  int   cur_sout;

  usr_if #(.WIDTH(W)) bus ();

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of n single-bit steps with a constant fill bit, as whole-word arithmetic.
  function automatic int model_q(input int q0, input op_e o, input int n, input bit s);
    int r;
    case (o)
      SHL:     r = (q0 << n) | (s ? ((1 << n) - 1) : 0);
      SHR:     r = (q0 >> n) | (s ? (MASK & ~(MASK >> n)) : 0);
      ROL:     r = (q0 << n) | (q0 >> (W - n));
      default: r = (q0 >> n) | (q0 << (W - n));
    endcase
    return r & MASK;
  endfunction

  // Last bit leaving the word after n>=1 steps.
  function automatic int model_sout(input int q0, input op_e o, input int n);
    if (o == SHL || o == ROL) return (q0 >> (W - n)) & 1;
    return (q0 >> (n - 1)) & 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    bus.load  = 1'b1;
    bus.d_par = v[W-1:0];
    tick();
    bus.load = 1'b0;
    cur_q    = v & MASK;
    chk("load_q", 32'(bus.q), cur_q);
    chk("load_qbar", 32'(bus.qbar), (~cur_q) & MASK);
    chk("load_busy", 32'(bus.busy), 0);
  endtask

  // Issue one operation and check every cycle up to the return to IDLE.
  task automatic run_op(input op_e o, input int amt, input bit s, input bit noise);
    int n;
    int q0;
    n  = (amt > W) ? W : amt;
    q0 = cur_q;
    bus.start  = 1'b1;
    bus.op     = o;
    bus.amount = amt[3:0];
    bus.sin    = s;
    tick();
    bus.start = 1'b0;
    chk("e0_busy", 32'(bus.busy), 1);
    chk("e0_done", 32'(bus.done), (n == 0) ? 1 : 0);
    for (int i = 1; i <= n + 1; i++) begin
      if (noise) begin
        bus.load   = 1'($urandom_range(0, 1));
        bus.start  = 1'($urandom_range(0, 1));
        bus.d_par  = 8'($urandom());
        bus.op     = op_e'($urandom_range(0, 3));
        bus.amount = 4'($urandom_range(0, 15));
      end
      tick();
      if (i <= n) begin
        chk("step_q", 32'(bus.q), model_q(q0, o, i, s));
        chk("step_sout", 32'(bus.sout), model_sout(q0, o, i));
        chk("step_busy", 32'(bus.busy), 1);
        chk("step_done", 32'(bus.done), (i == n) ? 1 : 0);
      end
    end
    bus.load  = 1'b0;
    bus.start = 1'b0;
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_done", 32'(bus.done), 0);
    chk("end_q", 32'(bus.q), model_q(q0, o, n, s));
    if (n > 0) cur_sout = model_sout(q0, o, n);
    chk("end_sout", 32'(bus.sout), cur_sout);
    cur_q = model_q(q0, o, n, s);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    cur_sout   = 0;
    reset      = 1'b0;
    bus.load   = 1'b1;
    bus.d_par  = 8'hA5;
    bus.start  = 1'b0;
    bus.op     = SHL;
    bus.amount = '0;
    bus.sin    = 1'b0;
    tick();
    tick();
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_qbar", 32'(bus.qbar), 8'hFF);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sout", 32'(bus.sout), 0);
    reset = 1'b1;
    do_load(8'hA5);

    do_load(8'h81);
    run_op(ROL, 3, 1'b0, 1'b0);
    chk("rol_q", 32'(bus.q), 8'h0C);

    do_load(8'hF0);
    run_op(SHR, 4, 1'b1, 1'b0);
    chk("shr_q", 32'(bus.q), 8'hFF);

    do_load(8'hA5);
    run_op(SHL, 15, 1'b0, 1'b0);
    chk("shl_clamp_q", 32'(bus.q), 8'h00);
    chk("shl_clamp_sout", 32'(bus.sout), 1);

    // load wins over a simultaneous start
    bus.start  = 1'b1;
    bus.op     = ROL;
    bus.amount = 4'd2;
    do_load(8'h3C);
    bus.start = 1'b0;
    tick();
    chk("conflict_busy", 32'(bus.busy), 0);
    chk("conflict_done", 32'(bus.done), 0);
    chk("conflict_q", 32'(bus.q), 8'h3C);

    run_op(ROR, 0, 1'b0, 1'b0);
    chk("zero_q", 32'(bus.q), 8'h3C);

    run_op(ROR, 5, 1'b1, 1'b1);

    // reset after two of five SHL steps
    do_load(8'h5A);
    bus.start  = 1'b1;
    bus.op     = SHL;
    bus.amount = 4'd5;
    bus.sin    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("pre_abort_q", 32'(bus.q), model_q(8'h5A, SHL, 2, 1'b1));
    reset = 1'b0;
    #1;
    chk("abort_q", 32'(bus.q), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_sout", 32'(bus.sout), 0);
    tick();
    reset    = 1'b1;
    cur_q    = 0;
    cur_sout = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.done), 0);
      chk("abort_idle_busy", 32'(bus.busy), 0);
    end
    do_load(8'hC3);
    run_op(SHR, 2, 1'b0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) do_load(int'($urandom_range(0, 255)));
      run_op(op_e'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
